// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bus between decode/write-back (master) and regfile_sb (slave).
// Ports grouped here:
//   srcA/srcB   read addresses           valA/valB   read data
//   busyA/busyB operand has a pending producer
//   destE/destM write-back addresses     valE/valM   write-back data
//   resv_en/resv_dst reserve a pending write; resv_full reservation refused
//   sb_err      sticky scoreboard underflow flag
interface regfile_sb_if #(
    parameter int DATA_WID = 32,
    parameter int ADDR_WID = 4
);
    logic [ADDR_WID-1:0] srcA, srcB, destE, destM, resv_dst;
    logic [DATA_WID-1:0] valA, valB, valE, valM;
    logic                busyA, busyB, resv_en, resv_full, sb_err;

    modport master (
        output srcA, srcB, destE, destM, valE, valM, resv_en, resv_dst,
        input  valA, valB, busyA, busyB, resv_full, sb_err
    );
    modport slave (
        input  srcA, srcB, destE, destM, valE, valM, resv_en, resv_dst,
        output valA, valB, busyA, busyB, resv_full, sb_err
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: register file with two combinational read ports, two write-back
// ports (M wins over E on the same register) and a per-register pending-write
// scoreboard counter.
// Ports: CLK, RST_N (async active-low clear of data, counters and sb_err),
//        bus (regfile_sb_if.slave) carrying read, write-back and reservation signals.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read
// ports and to report busy against the count left after this cycle's retirements.
module regfile_sb #(
    parameter int                  DATA_WID   = 32,
    parameter int                  ADDR_WID   = 4,
    parameter int                  NUM_OF_REG = 15,
    parameter logic [ADDR_WID-1:0] RNONE      = 4'hF,
    parameter int                  CNT_WID    = 2
) (
    input logic          CLK,
    input logic          RST_N,
    regfile_sb_if.slave  bus
);
    // Arithmetic width wide enough for cnt + inc and a dec of up to 2
    localparam int W = CNT_WID + 2;
    localparam logic [CNT_WID-1:0] CMAX = '1;

    logic [DATA_WID-1:0] data [NUM_OF_REG];
    logic [CNT_WID-1:0]  cnt  [NUM_OF_REG];
    logic [W-1:0]        dec  [NUM_OF_REG];
    logic [NUM_OF_REG-1:0] under;
    logic sbErr, vA, vB, vE, vM, vR;

    function automatic logic isValid(input logic [ADDR_WID-1:0] a);
        return a != RNONE && 32'(a) < NUM_OF_REG;
    endfunction

    assign vA = isValid(bus.srcA);
    assign vB = isValid(bus.srcB);
    assign vE = isValid(bus.destE);
    assign vM = isValid(bus.destM);
    assign vR = isValid(bus.resv_dst);

    for (genvar r = 0; r < NUM_OF_REG; r++) begin : g_reg
        localparam logic [ADDR_WID-1:0] ADDR = ADDR_WID'(r);
        logic [DATA_WID-1:0] q;
        logic [CNT_WID-1:0]  c;
        logic [W-1:0]        sum;
        logic                hitE, hitM, inc;
        assign hitE   = vE && bus.destE == ADDR;
        assign hitM   = vM && bus.destM == ADDR;
        // A saturated counter refuses the reservation rather than wrapping
        assign inc    = bus.resv_en && vR && bus.resv_dst == ADDR && c != CMAX;
        assign dec[r] = W'(hitE) + W'(hitM);
        assign sum    = W'(c) + W'(inc);
        assign under[r] = dec[r] > sum;
        assign data[r]  = q;
        assign cnt[r]   = c;
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                q <= '0;
                c <= '0;
            end else begin
                q <= hitM ? bus.valM : hitE ? bus.valE : q;
                c <= under[r] ? '0 : CNT_WID'(sum - dec[r]);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) sbErr <= 1'b0;
        else if (|under) sbErr <= 1'b1;
    end

    assign bus.sb_err    = sbErr;
    assign bus.resv_full = bus.resv_en && vR && cnt[bus.resv_dst] == CMAX;

`ifdef REGFILE_BYPASS_EN
    assign bus.valA = !vA ? '0 : (vM && bus.destM == bus.srcA) ? bus.valM :
                      (vE && bus.destE == bus.srcA) ? bus.valE : data[bus.srcA];
    assign bus.valB = !vB ? '0 : (vM && bus.destM == bus.srcB) ? bus.valM :
                      (vE && bus.destE == bus.srcB) ? bus.valE : data[bus.srcB];
    // Busy only if producers remain after this cycle's retirements
    assign bus.busyA = vA && W'(cnt[bus.srcA]) > dec[bus.srcA];
    assign bus.busyB = vB && W'(cnt[bus.srcB]) > dec[bus.srcB];
`else
    assign bus.valA  = vA ? data[bus.srcA] : '0;
    assign bus.valB  = vB ? data[bus.srcB] : '0;
    assign bus.busyA = vA && cnt[bus.srcA] != '0;
    assign bus.busyB = vB && cnt[bus.srcB] != '0;
`endif
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the pipeline register file: two combinational read ports, two write-back ports (E and M), asynchronous clear of all registers, and an integrated per-register pending-write scoreboard. Decode uses it to read operands and to learn whether each operand still has an in-flight producer. Write-back drives destE/destM. An optional same-cycle write-to-read bypass is compiled in by macro.

## Interface
- DATA_WID, 32, register data width
- ADDR_WID, 4, register address width
- NUM_OF_REG, 15, number of implemented registers, addresses 0..NUM_OF_REG-1
- RNONE, 4'hF, "no register" address; never stored, never reserved
- CNT_WID, 2, scoreboard counter width per register

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- srcA, srcB  in  ADDR_WID  read addresses
- valA, valB  out  DATA_WID  read data
- busyA, busyB  out  1  operand has a pending producer
- destE, destM  in  ADDR_WID  write-back addresses; RNONE means no write
- valE, valM  in  DATA_WID  write-back data
- resv_en  in  1  reserve a pending write to resv_dst
- resv_dst  in  ADDR_WID  register to reserve
- resv_full  out  1  resv_dst counter saturated; a reservation this cycle is refused
- sb_err  out  1  sticky; a write-back hit a register whose counter was 0

## Operation
- Valid address: != RNONE and < NUM_OF_REG. Writes, reservations and reads to invalid addresses are ignored. Reads of invalid addresses return 0 with busy=0.
- Writes, on posedge CLK:
  - data[destE] <= valE if destE is valid.
  - data[destM] <= valM if destM is valid.
  - destE == destM (both valid): valM is stored. M has priority.
- Reads are combinational: valX = data[srcX].
- Scoreboard: cnt[r] is a CNT_WID-bit counter. Each posedge, cnt[r] becomes cnt[r] + inc − dec.
  - inc = 1 iff resv_en, resv_dst == r is valid, and cnt[r] != max (2^CNT_WID−1).
  - dec = number of valid write ports addressing r (0, 1 or 2).
  - If dec > cnt[r] + inc, the result clamps to 0 and sb_err sets.
- resv_full = resv_en && resv_dst valid && cnt[resv_dst] == max (combinational). A refused reservation leaves the counter unchanged.
- busyX = srcX valid && cnt[srcX] != 0. This applies without bypass; see Configuration for the bypass case.
- Reserve and write-back to the same register in the same cycle: both apply (net inc − dec).

## Timing
- Reset, asynchronous, while RST_N == 0:
  - all data = 0, all cnt = 0, sb_err = 0.
  - Reads therefore return 0 with busy = 0 immediately.
- Reset asserted mid-operation discards all pending counts and data without waiting for a clock. First write after deassertion takes effect on the first posedge with RST_N == 1.
- Write latency: data is visible on valX the cycle after the write edge (without bypass).
- Reservation latency: busyX rises the cycle after the reserving edge.
- sb_err is cleared only by reset.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If srcX equals a valid destM, valX = valM; else if it equals a valid destE, valX = valE.
  - On such a hit, busyX = (cnt[srcX] − dec) != 0, clamped at 0. An operand whose last producer writes back this cycle reads as ready.
- REGFILE_BYPASS_EN undefined: reads come only from the array; busy uses the registered count.

## Test plan
- Reset: hold RST_N=0 mid-run after writes → valA=valB=0, busyA=busyB=0, sb_err=0 without any clock edge.
- Dual write same register: destE=destM=3, valE=0x11, valM=0x22, edge → valA(srcA=3)=0x22. destE=RNONE, destM=2, valM=0x5 → r2=5 and no other register changes.
- Scoreboard: reserve r4 three times → busyA(src=4)=1; a fourth reserve gives resv_full=1 and cnt stays 3. Three write-backs to r4 → busyA=0 after the third edge. A further write-back sets sb_err=1.
- Simultaneous reserve and retire of r6 with cnt=1 → cnt stays 1, busy stays 1.
- Bypass (macro on): cnt[7]=1, destE=7, valE=0xAB, srcA=7 in the same cycle → valA=0xAB, busyA=0. Macro off → valA=old value, busyA=1.
- Invalid addresses: srcB=RNONE → valB=0, busyB=0. destE=15 writes nothing.
